// File: rtl/sdf_delay_stage.sv
// Radix-2 single-delay-feedback FFT stage: pairs x[k] with x[k+DEPTH], emits the scaled
// sum half paced by the input, then drains the stored difference half back-to-back.
//
// state | meaning
// ------+---------------------------------------------------------------
// FILL  | first half-frame: store x[0..DEPTH-1], drain of previous y1 may run
// BFLY  | second half-frame: butterfly, emit y0, store y1 in place of a
module sdf_delay_stage #(
   parameter int WIDTH = 14,
   parameter int DEPTH = 32,
   parameter int RH    = 0
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    di_en,
   input  logic signed [WIDTH-1:0] di_re,
   input  logic signed [WIDTH-1:0] di_im,
   output logic                    do_en,
   output logic signed [WIDTH-1:0] do_re,
   output logic signed [WIDTH-1:0] do_im
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   typedef enum logic {
      S_FILL = 1'b0,
      S_BFLY = 1'b1
   } state_t;

   state_t              state;
   state_t              state_nx;
   logic [AW-1:0]       fill_idx;
   logic [AW-1:0]       drain_idx;
   logic [AW-1:0]       rd_idx;
   logic                drain_act;
   logic                fill_last;
   logic                drain_last;

   logic [2*WIDTH-1:0]  mem [DEPTH];
   logic [2*WIDTH-1:0]  rd_data;
   logic [2*WIDTH-1:0]  wr_data;
   logic                wr_en;
   logic                bfly_acc;

   logic [WIDTH-1:0]    a_re;
   logic [WIDTH-1:0]    a_im;
   logic [WIDTH-1:0]    y0_re;
   logic [WIDTH-1:0]    y0_im;
   logic [WIDTH-1:0]    y1_re;
   logic [WIDTH-1:0]    y1_im;

   // Sum/difference at WIDTH+1 bits, add the rounding constant, halve and keep WIDTH bits.
   function automatic logic [WIDTH-1:0] half_bfly(
      input logic [WIDTH-1:0] a,
      input logic [WIDTH-1:0] b,
      input logic             sub
   );
      logic [WIDTH:0] ax;
      logic [WIDTH:0] bx;
      logic [WIDTH:0] s;
      ax = {a[WIDTH-1], a};
      bx = {b[WIDTH-1], b};
      s  = sub ? (ax - bx) : (ax + bx);
      s  = s + (WIDTH+1)'(RH);
      return s[WIDTH:1];
   endfunction

   assign fill_last  = (fill_idx == LAST_IDX);
   assign drain_last = (drain_idx == LAST_IDX);

   // Drain never overlaps BFLY, so a single read port serves both users.
   assign rd_idx  = (state == S_BFLY) ? fill_idx : drain_idx;
   assign rd_data = mem[rd_idx];
   assign a_re    = rd_data[2*WIDTH-1:WIDTH];
   assign a_im    = rd_data[WIDTH-1:0];

   always_comb begin
      y0_re = half_bfly(a_re, di_re, 1'b0);
      y0_im = half_bfly(a_im, di_im, 1'b0);
      y1_re = half_bfly(a_re, di_re, 1'b1);
      y1_im = half_bfly(a_im, di_im, 1'b1);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_FILL;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_FILL:  if (di_en && fill_last) state_nx = S_BFLY;
         S_BFLY:  if (di_en && fill_last) state_nx = S_FILL;
         default: state_nx = S_FILL;
      endcase
   end

   always_comb begin
      wr_en    = 1'b0;
      bfly_acc = 1'b0;
      wr_data  = {di_re, di_im};
      case (state)
         S_FILL: begin
            wr_en = di_en;
         end
         S_BFLY: begin
            wr_en    = di_en;
            bfly_acc = di_en;
            wr_data  = {y1_re, y1_im};
         end
         default: begin
            wr_en = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         fill_idx <= '0;
      end else if (di_en) begin
         fill_idx <= fill_idx + 1'b1;
      end
   end

   // Drain is armed by the last butterfly and runs DEPTH cycles regardless of di_en.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         drain_act <= 1'b0;
         drain_idx <= '0;
      end else if (bfly_acc && fill_last) begin
         drain_act <= 1'b1;
         drain_idx <= '0;
      end else if (drain_act) begin
         drain_idx <= drain_idx + 1'b1;
         if (drain_last) drain_act <= 1'b0;
      end
   end

   // Storage is not reset; the combinational read above sees the pre-write value.
   always_ff @(posedge clock) begin
      if (wr_en) mem[fill_idx] <= wr_data;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         do_en <= 1'b0;
         do_re <= '0;
         do_im <= '0;
      end else if (bfly_acc) begin
         do_en <= 1'b1;
         do_re <= y0_re;
         do_im <= y0_im;
      end else if (drain_act) begin
         do_en <= 1'b1;
         do_re <= a_re;
         do_im <= a_im;
      end else begin
         do_en <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sdf_delay_stage.sv
// Bench for sdf_delay_stage: two instances (RH=0 and RH=1) share the stimulus and are
// compared against a frame-level butterfly model with expected output cycle stamps.
module tb_sdf_delay_stage;

   localparam int W = 14;
   localparam int D = 4;

   logic                clock   = 1'b0;
   logic                reset_n = 1'b0;
   logic                di_en   = 1'b0;
   logic signed [W-1:0] di_re   = '0;
   logic signed [W-1:0] di_im   = '0;
   logic                do_en0, do_en1;
   logic signed [W-1:0] do_re0, do_im0, do_re1, do_im1;

   sdf_delay_stage #(.WIDTH(W), .DEPTH(D), .RH(0)) u0 (
      .clock(clock), .reset_n(reset_n), .di_en(di_en), .di_re(di_re), .di_im(di_im),
      .do_en(do_en0), .do_re(do_re0), .do_im(do_im0));

   sdf_delay_stage #(.WIDTH(W), .DEPTH(D), .RH(1)) u1 (
      .clock(clock), .reset_n(reset_n), .di_en(di_en), .di_re(di_re), .di_im(di_im),
      .do_en(do_en1), .do_re(do_re1), .do_im(do_im1));

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc++;

   typedef struct packed { int cyc; int re; int im; } smp_t;
   smp_t obs0[$], obs1[$], exp0[$], exp1[$];

   int n_tests = 0;
   int n_fail  = 0;
   int hold_err = 0;
   logic [W-1:0] last_re0 = '0, last_im0 = '0, last_re1 = '0, last_im1 = '0;

   int fr_re[2*D];
   int fr_im[2*D];

   always @(negedge clock) begin
      if (do_en0) obs0.push_back(smp_t'{cyc, int'(do_re0), int'(do_im0)});
      else if (reset_n === 1'b1 && (do_re0 !== last_re0 || do_im0 !== last_im0)) hold_err++;
      if (do_en1) obs1.push_back(smp_t'{cyc, int'(do_re1), int'(do_im1)});
      else if (reset_n === 1'b1 && (do_re1 !== last_re1 || do_im1 !== last_im1)) hold_err++;
      last_re0 = do_re0; last_im0 = do_im0;
      last_re1 = do_re1; last_im1 = do_im1;
   end

   function automatic int wrapw(int v);
      int m;
      m = v & ((1 << W) - 1);
      return (m >= (1 << (W - 1))) ? m - (1 << W) : m;
   endfunction

   // floor((a +/- b + rh) / 2), wrapped to W bits
   function automatic int bf(int a, int b, int rh, bit sub);
      int s;
      s = sub ? a - b : a + b;
      return wrapw((s + rh) >>> 1);
   endfunction

   function automatic int rnd();
      return int'($urandom_range(16383)) - 8192;
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clock);
         di_en = 1'b0;
      end
   endtask

   // Drives fr_re/fr_im as one frame and queues the expected outputs with cycle stamps.
   task automatic drive_frame(input int gap_pct);
      int acc[2*D];
      for (int i = 0; i < 2*D; i++) begin
         while (int'($urandom_range(99)) < gap_pct) begin
            @(negedge clock);
            di_en = 1'b0;
         end
         @(negedge clock);
         di_en = 1'b1;
         di_re = W'(fr_re[i]);
         di_im = W'(fr_im[i]);
         acc[i] = cyc + 1;
      end
      for (int k = 0; k < D; k++) begin
         exp0.push_back(smp_t'{acc[D+k], bf(fr_re[k], fr_re[D+k], 0, 0), bf(fr_im[k], fr_im[D+k], 0, 0)});
         exp1.push_back(smp_t'{acc[D+k], bf(fr_re[k], fr_re[D+k], 1, 0), bf(fr_im[k], fr_im[D+k], 1, 0)});
      end
      for (int k = 0; k < D; k++) begin
         exp0.push_back(smp_t'{acc[2*D-1]+1+k, bf(fr_re[k], fr_re[D+k], 0, 1), bf(fr_im[k], fr_im[D+k], 0, 1)});
         exp1.push_back(smp_t'{acc[2*D-1]+1+k, bf(fr_re[k], fr_re[D+k], 1, 1), bf(fr_im[k], fr_im[D+k], 1, 1)});
      end
   endtask

   task automatic clear_q();
      obs0.delete(); obs1.delete(); exp0.delete(); exp1.delete();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clock);
      n_tests++;
      if (do_en0 !== 1'b0 || do_re0 !== '0 || do_im0 !== '0 ||
          do_en1 !== 1'b0 || do_re1 !== '0 || do_im1 !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got en=%b/%b re=%0d/%0d im=%0d/%0d want all 0",
                  do_en0, do_en1, do_re0, do_re1, do_im0, do_im1);
      end
      reset_n = 1'b1;
      idle(6);
      n_tests++;
      if (obs0.size() != 0 || obs1.size() != 0) begin
         n_fail++;
         $display("FAIL reset_idle: got %0d/%0d outputs want 0", obs0.size(), obs1.size());
      end
      clear_q();
   endtask

   task automatic test_basic();
      int lit[2*D] = '{4, 4, 4, 4, 4, 2, 0, -2};
      fr_re = '{8, 6, 4, 2, 0, 2, 4, 6};
      fr_im = '{0, 0, 0, 0, 0, 0, 0, 0};
      drive_frame(0);
      idle(12);
      n_tests++;
      if (obs0.size() != exp0.size() || obs1.size() != exp1.size()) begin
         n_fail++;
         $display("FAIL basic_count: got %0d/%0d want %0d/%0d", obs0.size(), obs1.size(), exp0.size(), exp1.size());
      end
      for (int i = 0; i < exp0.size() && i < obs0.size(); i++) begin
         n_tests++;
         if (obs0[i] !== exp0[i]) begin
            n_fail++;
            $display("FAIL basic_rh0[%0d]: got c=%0d re=%0d im=%0d want c=%0d re=%0d im=%0d",
                     i, obs0[i].cyc, obs0[i].re, obs0[i].im, exp0[i].cyc, exp0[i].re, exp0[i].im);
         end
      end
      for (int i = 0; i < exp1.size() && i < obs1.size(); i++) begin
         n_tests++;
         if (obs1[i] !== exp1[i]) begin
            n_fail++;
            $display("FAIL basic_rh1[%0d]: got c=%0d re=%0d im=%0d want c=%0d re=%0d im=%0d",
                     i, obs1[i].cyc, obs1[i].re, obs1[i].im, exp1[i].cyc, exp1[i].re, exp1[i].im);
         end
      end
      for (int i = 0; i < 2*D && i < obs0.size(); i++) begin
         n_tests++;
         if (obs0[i].re !== lit[i] || obs0[i].cyc !== obs0[0].cyc + i) begin
            n_fail++;
            $display("FAIL basic_literal[%0d]: got re=%0d c=%0d want re=%0d c=%0d",
                     i, obs0[i].re, obs0[i].cyc, lit[i], obs0[0].cyc + i);
         end
      end
      clear_q();
   endtask

   task automatic test_rounding();
      fr_re = '{3, -3, rnd(), rnd(), 0, 0, rnd(), rnd()};
      for (int i = 0; i < 2*D; i++) fr_im[i] = rnd();
      drive_frame(0);
      idle(12);
      n_tests++;
      if (obs0.size() != exp0.size() || obs1.size() != exp1.size()) begin
         n_fail++;
         $display("FAIL round_count: got %0d/%0d want %0d/%0d", obs0.size(), obs1.size(), exp0.size(), exp1.size());
      end
      for (int i = 0; i < exp0.size() && i < obs0.size(); i++) begin
         n_tests++;
         if (obs0[i] !== exp0[i]) begin
            n_fail++;
            $display("FAIL round_rh0[%0d]: got c=%0d re=%0d im=%0d want c=%0d re=%0d im=%0d",
                     i, obs0[i].cyc, obs0[i].re, obs0[i].im, exp0[i].cyc, exp0[i].re, exp0[i].im);
         end
      end
      for (int i = 0; i < exp1.size() && i < obs1.size(); i++) begin
         n_tests++;
         if (obs1[i] !== exp1[i]) begin
            n_fail++;
            $display("FAIL round_rh1[%0d]: got c=%0d re=%0d im=%0d want c=%0d re=%0d im=%0d",
                     i, obs1[i].cyc, obs1[i].re, obs1[i].im, exp1[i].cyc, exp1[i].re, exp1[i].im);
         end
      end
      if (obs0.size() >= 2*D && obs1.size() >= 2*D) begin
         n_tests++;
         if (obs0[0].re !== 1 || obs0[4].re !== 1 || obs1[0].re !== 2 || obs1[4].re !== 2 ||
             obs0[1].re !== -2 || obs1[1].re !== -1) begin
            n_fail++;
            $display("FAIL round_literal: got %0d %0d %0d %0d %0d %0d want 1 1 2 2 -2 -1",
                     obs0[0].re, obs0[4].re, obs1[0].re, obs1[4].re, obs0[1].re, obs1[1].re);
         end
      end
      clear_q();
   endtask

   task automatic test_extremes();
      fr_re = '{8191, -8192, rnd(), rnd(), 8191, 8191, rnd(), rnd()};
      fr_im = '{8191, 8191, rnd(), rnd(), 8191, -8192, rnd(), rnd()};
      drive_frame(0);
      idle(12);
      n_tests++;
      if (obs0.size() != exp0.size() || obs1.size() != exp1.size()) begin
         n_fail++;
         $display("FAIL ext_count: got %0d/%0d want %0d/%0d", obs0.size(), obs1.size(), exp0.size(), exp1.size());
      end
      for (int i = 0; i < exp0.size() && i < obs0.size(); i++) begin
         n_tests++;
         if (obs0[i] !== exp0[i]) begin
            n_fail++;
            $display("FAIL ext_rh0[%0d]: got c=%0d re=%0d im=%0d want c=%0d re=%0d im=%0d",
                     i, obs0[i].cyc, obs0[i].re, obs0[i].im, exp0[i].cyc, exp0[i].re, exp0[i].im);
         end
      end
      for (int i = 0; i < exp1.size() && i < obs1.size(); i++) begin
         n_tests++;
         if (obs1[i] !== exp1[i]) begin
            n_fail++;
            $display("FAIL ext_rh1[%0d]: got c=%0d re=%0d im=%0d want c=%0d re=%0d im=%0d",
                     i, obs1[i].cyc, obs1[i].re, obs1[i].im, exp1[i].cyc, exp1[i].re, exp1[i].im);
         end
      end
      if (obs0.size() >= 2*D) begin
         n_tests++;
         if (obs0[0].re !== 8191 || obs0[4].re !== 0 || obs0[1].re !== -1 || obs0[5].re !== -8192 ||
             obs0[1].im !== -1 || obs0[5].im !== 8191) begin
            n_fail++;
            $display("FAIL ext_literal: got %0d %0d %0d %0d %0d %0d want 8191 0 -1 -8192 -1 8191",
                     obs0[0].re, obs0[4].re, obs0[1].re, obs0[5].re, obs0[1].im, obs0[5].im);
         end
      end
      clear_q();
   endtask

   task automatic test_back_to_back();
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < 2*D; i++) begin
            fr_re[i] = rnd();
            fr_im[i] = rnd();
         end
         drive_frame(0);
      end
      idle(12);
      n_tests++;
      if (obs0.size() != exp0.size() || obs1.size() != exp1.size()) begin
         n_fail++;
         $display("FAIL b2b_count: got %0d/%0d want %0d/%0d", obs0.size(), obs1.size(), exp0.size(), exp1.size());
      end
      for (int i = 0; i < exp0.size() && i < obs0.size(); i++) begin
         n_tests++;
         if (obs0[i] !== exp0[i]) begin
            n_fail++;
            $display("FAIL b2b_rh0[%0d]: got c=%0d re=%0d im=%0d want c=%0d re=%0d im=%0d",
                     i, obs0[i].cyc, obs0[i].re, obs0[i].im, exp0[i].cyc, exp0[i].re, exp0[i].im);
         end
      end
      for (int i = 0; i < exp1.size() && i < obs1.size(); i++) begin
         n_tests++;
         if (obs1[i] !== exp1[i]) begin
            n_fail++;
            $display("FAIL b2b_rh1[%0d]: got c=%0d re=%0d im=%0d want c=%0d re=%0d im=%0d",
                     i, obs1[i].cyc, obs1[i].re, obs1[i].im, exp1[i].cyc, exp1[i].re, exp1[i].im);
         end
      end
      clear_q();
   endtask

   task automatic test_gaps();
      int lit[2*D] = '{4, 4, 4, 4, 4, 2, 0, -2};
      hold_err = 0;
      fr_re = '{8, 6, 4, 2, 0, 2, 4, 6};
      fr_im = '{0, 0, 0, 0, 0, 0, 0, 0};
      drive_frame(50);
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < 2*D; i++) begin
            fr_re[i] = rnd();
            fr_im[i] = rnd();
         end
         drive_frame(50);
      end
      idle(12);
      n_tests++;
      if (obs0.size() != exp0.size() || obs1.size() != exp1.size()) begin
         n_fail++;
         $display("FAIL gap_count: got %0d/%0d want %0d/%0d", obs0.size(), obs1.size(), exp0.size(), exp1.size());
      end
      for (int i = 0; i < exp0.size() && i < obs0.size(); i++) begin
         n_tests++;
         if (obs0[i] !== exp0[i]) begin
            n_fail++;
            $display("FAIL gap_rh0[%0d]: got c=%0d re=%0d im=%0d want c=%0d re=%0d im=%0d",
                     i, obs0[i].cyc, obs0[i].re, obs0[i].im, exp0[i].cyc, exp0[i].re, exp0[i].im);
         end
      end
      for (int i = 0; i < exp1.size() && i < obs1.size(); i++) begin
         n_tests++;
         if (obs1[i] !== exp1[i]) begin
            n_fail++;
            $display("FAIL gap_rh1[%0d]: got c=%0d re=%0d im=%0d want c=%0d re=%0d im=%0d",
                     i, obs1[i].cyc, obs1[i].re, obs1[i].im, exp1[i].cyc, exp1[i].re, exp1[i].im);
         end
      end
      for (int i = 0; i < 2*D && i < obs0.size(); i++) begin
         n_tests++;
         if (obs0[i].re !== lit[i]) begin
            n_fail++;
            $display("FAIL gap_literal[%0d]: got re=%0d want %0d", i, obs0[i].re, lit[i]);
         end
      end
      n_tests++;
      if (hold_err != 0) begin
         n_fail++;
         $display("FAIL gap_hold: got %0d idle-cycle output changes want 0", hold_err);
      end
      clear_q();
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 2*D; i++) begin
         fr_re[i] = rnd();
         fr_im[i] = rnd();
      end
      for (int i = 0; i < D + 2; i++) begin
         @(negedge clock);
         di_en = 1'b1;
         di_re = W'(fr_re[i]);
         di_im = W'(fr_im[i]);
      end
      @(negedge clock);
      di_en = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      n_tests++;
      if (do_en0 !== 1'b0 || do_re0 !== '0 || do_im0 !== '0 ||
          do_en1 !== 1'b0 || do_re1 !== '0 || do_im1 !== '0) begin
         n_fail++;
         $display("FAIL midreset_async: got en=%b/%b re=%0d/%0d im=%0d/%0d want all 0",
                  do_en0, do_en1, do_re0, do_re1, do_im0, do_im1);
      end
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      clear_q();
      idle(10);
      n_tests++;
      if (obs0.size() != 0 || obs1.size() != 0) begin
         n_fail++;
         $display("FAIL midreset_stale: got %0d/%0d outputs want 0", obs0.size(), obs1.size());
      end
      clear_q();
      for (int i = 0; i < 2*D; i++) begin
         fr_re[i] = rnd();
         fr_im[i] = rnd();
      end
      drive_frame(0);
      idle(12);
      n_tests++;
      if (obs0.size() != exp0.size() || obs1.size() != exp1.size()) begin
         n_fail++;
         $display("FAIL midreset_count: got %0d/%0d want %0d/%0d", obs0.size(), obs1.size(), exp0.size(), exp1.size());
      end
      for (int i = 0; i < exp0.size() && i < obs0.size(); i++) begin
         n_tests++;
         if (obs0[i] !== exp0[i]) begin
            n_fail++;
            $display("FAIL midreset_rh0[%0d]: got c=%0d re=%0d im=%0d want c=%0d re=%0d im=%0d",
                     i, obs0[i].cyc, obs0[i].re, obs0[i].im, exp0[i].cyc, exp0[i].re, exp0[i].im);
         end
      end
      for (int i = 0; i < exp1.size() && i < obs1.size(); i++) begin
         n_tests++;
         if (obs1[i] !== exp1[i]) begin
            n_fail++;
            $display("FAIL midreset_rh1[%0d]: got c=%0d re=%0d im=%0d want c=%0d re=%0d im=%0d",
                     i, obs1[i].cyc, obs1[i].re, obs1[i].im, exp1[i].cyc, exp1[i].re, exp1[i].im);
         end
      end
      clear_q();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_rounding();
      test_extremes();
      test_back_to_back();
      test_gaps();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
